spm_seq_mult: RTL
=================

Name: spm_seq_mult

Overview:
- Parametrised, handshaked serial-parallel multiplier that generalises the fixed-width spm CSA chain.
- The x operand is held in parallel across a WIDTH-cell carry-save chain. The y operand is shifted in LSB-first.
- Product bits stream out serially, LSB-first, and the full 2*WIDTH-bit product is also assembled for a parallel read.
- Adds a runtime signed/unsigned mode, valid/ready on both sides, and a synchronous flush. Sits between operand sequencing logic and downstream accumulators.

Parameters:
- WIDTH, 32: operand width in bits; legal range 2 to 64.
- CNT_W, $clog2(2*WIDTH): width of the cycle counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  parallel multiplicand.
- y  input  WIDTH  multiplier, serialised internally.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- p_bit  output  1  serial product bit, LSB first.
- p_bit_valid  output  1  p_bit carries a live product bit.
- out_valid  output  1  full product available.
- out_ready  input  1  downstream consumes the product.
- p  output  2*WIDTH  parallel product.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - x_reg, y_sh, all sum/carry registers, the two's-complement register, cnt and p are cleared to 0.
  - Outputs after reset: in_ready=1, out_valid=0, p_bit_valid=0, p_bit=0, p=0, busy=0.
  - rst overrides every other input, including mid-RUN or mid-DONE.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch x, y and signed_mode; clear the chain registers, cnt and p; go to RUN.
- RUN:
  - Lasts exactly 2*WIDTH cycles, cnt = 0 to 2*WIDTH-1.
  - Serial y input:
    - cnt < WIDTH: yb = y_sh[0], then y_sh shifts right.
    - cnt >= WIDTH: yb = y_reg[WIDTH-1] when signed_mode=1, else yb = 0.
  - CSA cell i, for i = 0 to WIDTH-1:
    - a_i = x_reg[i] & yb.
    - b_i = s_{i+1} for i < WIDTH-1.
    - s_i <= a_i ^ b_i ^ c_i.
    - c_i <= majority(a_i, b_i, c_i).
  - Top-cell input b_{WIDTH-1}:
    - Unsigned mode: 0.
    - Signed mode: the serial two's complement of t = x_reg[WIDTH-1] & yb, i.e. b = t ^ z with z <= z | t.
  - Serial output:
    - p_bit = s_0 after the cycle-cnt update; p_bit_valid=1 in the cycle following each RUN update.
    - Product bit k is therefore presented k+1 cycles after the accept edge, for k = 0 to 2*WIDTH-1.
    - Each bit shifts into p from the MSB side; after 2*WIDTH bits, p holds the full product.
  - At cnt = 2*WIDTH-1, go to DONE.
- Arithmetic:
  - p = (x*y) mod 2^(2*WIDTH).
  - Operands are interpreted per the latched signed_mode.
  - The result is exact for all operand values, including the most-negative-by-most-negative case.
- DONE:
  - out_valid=1; p is held stable.
  - On out_ready, go to IDLE. in_ready rises the cycle after out_ready is taken.
  - No new accept occurs in the same cycle as out_ready.
- Handshake rules:
  - in_ready=0 in RUN and DONE. in_valid is ignored there and operands are not latched.
  - out_valid and p must not change while out_valid=1 & out_ready=0.
  - Changing x, y or signed_mode during RUN has no effect.
- flush:
  - In any state, at the next edge: go to IDLE, clear the chain registers and cnt, out_valid=0, p_bit_valid=0.
  - p keeps its last value.
  - flush and rst together: rst wins, with the same end state except p=0.
  - flush together with in_valid in IDLE: flush wins, and the operands are not accepted.

Decomposition:
- Package spm_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - function cnt_width(w) returning $clog2(2*w).
- One sub-module, spm_csa_cell:
  - inputs clk, rst, clr, en, a, b;
  - outputs s, c;
  - one registered sum and one registered carry; instantiated WIDTH times via generate.
- The two's-complement top-input logic stays inline in spm_seq_mult.

Test Plan (WIDTH=8):
- Unsigned max: x=8'hFF, y=8'hFF, signed_mode=0 -> p=16'hFE01; the 16 p_bit values LSB-first match; out_valid exactly 17 cycles after the accept edge.
- Signed extremes: x=8'h80, y=8'h80, signed_mode=1 -> p=16'h4000. Also x=8'hFF, y=8'h01 -> p=16'hFFFF. Also x=8'h7F, y=8'h80 -> p=16'hC080.
- Back-pressure: after done, hold out_ready=0 for 5 cycles -> out_valid=1 and p constant throughout; in_valid=1 with new operands is ignored; operands are accepted only after out_ready and the return to IDLE.
- Flush mid-RUN: flush at cnt=5 -> next cycle state=IDLE, in_ready=1, p_bit_valid=0; a following 3*5 unsigned multiply gives p=16'h000F with no residue from the aborted run.
- Reset mid-DONE: rst with out_valid=1 -> next cycle out_valid=0, p=0, in_ready=1, busy=0.
- Randomised: 1000 random x, y, signed_mode pairs with random out_ready stalls -> p matches the modular reference product every time.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier.
package spm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save cell: registered sum passed down the chain, registered carry kept locally.
module spm_csa_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s <= 1'b0;
      c <= 1'b0;
    end else if (en) begin
      s <= a ^ b ^ c;
      c <= (a & b) | (a & c) | (b & c);
    end
  end

endmodule

// File: rtl/spm_seq_mult.sv
// Handshaked serial-parallel multiplier: x held across a CSA chain, y shifted in LSB-first,
// product streamed out LSB-first and assembled into p.
module spm_seq_mult
  import spm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 signed_mode,
  output logic                 p_bit,
  output logic                 p_bit_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(2 * WIDTH - 1);
  localparam logic [CNT_W-1:0] CntHalf = CNT_W'(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_sh;
  logic             y_sign;
  logic             sgn;
  logic             z;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c_unused;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             yb;
  logic             t;
  logic             accept;
  logic             run_en;
  logic             chain_clr;

  assign accept    = (state == StIdle) && in_valid && !flush;
  assign run_en    = (state == StRun) && !flush;
  assign chain_clr = accept || flush;

  // Upper half of the stream is the sign extension of y (zero when unsigned).
  assign yb = (cnt < CntHalf) ? y_sh[0] : y_sign;
  assign t  = x_reg[WIDTH-1] & yb;

  // In signed mode the top bit of x has negative weight, so its partial-product
  // stream enters the top cell negated (serial two's complement) instead of as a.
  always_comb begin
    a = x_reg & {WIDTH{yb}};
    b = {1'b0, s[WIDTH-1:1]};
    if (sgn) begin
      a[WIDTH-1] = 1'b0;
      b[WIDTH-1] = t ^ z;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    spm_csa_cell u_cell (
      .clk (clk),
      .rst (rst),
      .clr (chain_clr),
      .en  (run_en),
      .a   (a[i]),
      .b   (b[i]),
      .s   (s[i]),
      .c   (c_unused[i])
    );
  end

  assign p_bit    = s[0];
  assign in_ready = (state == StIdle);
  assign busy     = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      x_reg       <= '0;
      y_sh        <= '0;
      y_sign      <= 1'b0;
      sgn         <= 1'b0;
      z           <= 1'b0;
      cnt         <= '0;
      p           <= '0;
      p_bit_valid <= 1'b0;
      out_valid   <= 1'b0;
    end else if (flush) begin
      state       <= StIdle;
      z           <= 1'b0;
      cnt         <= '0;
      p_bit_valid <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      // Each presented bit is absorbed into p one cycle later, from the MSB side.
      if (p_bit_valid) begin
        p <= {p_bit, p[2*WIDTH-1:1]};
      end
      p_bit_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid) begin
            x_reg  <= x;
            y_sh   <= y;
            sgn    <= signed_mode;
            y_sign <= signed_mode & y[WIDTH-1];
            z      <= 1'b0;
            cnt    <= '0;
            p      <= '0;
            state  <= StRun;
          end
        end
        StRun: begin
          y_sh        <= y_sh >> 1;
          z           <= z | t;
          cnt         <= cnt + 1'b1;
          p_bit_valid <= 1'b1;
          if (cnt == CntLast) begin
            state <= StDone;
          end
        end
        StDone: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
